// File: rtl/per_uart_tx_pkg.sv
// Shared bus encodings, register offsets and FSM state type for the UART transmitter.
package per_uart_tx_pkg;

    // Slave-select encoding produced by the device select block
    localparam int SEL_W = 2;
    localparam logic [SEL_W-1:0] SEL_NONE   = 2'd0;
    localparam logic [SEL_W-1:0] SEL_MASTER = 2'd1;
    localparam logic [SEL_W-1:0] SEL_SLAVE  = 2'd2;

    // In-device address span of slot 3 (0x18000000-0x1FFFFFFF) and bus word width
    localparam int DEV_ADDR_W = 27;
    localparam int WORD_W     = 32;
    localparam int BYTE_W     = 8;

    // Bus direction
    localparam logic RW_R = 1'b0;
    localparam logic RW_W = 1'b1;

    // Register word offsets (addr_in[3:2])
    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_BAUD   = 2'd2;
    localparam logic [1:0] OFF_CTRL   = 2'd3;

    localparam logic [WORD_W-1:0] ZERO_WORD = '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // A divider of zero would never reach a bit boundary, so it is clamped to one
    function automatic logic [15:0] baud_sanitize(input logic [15:0] v);
        return (v == 16'd0) ? 16'd1 : v;
    endfunction

endpackage

// File: rtl/per_uart_fifo.sv
// Synchronous TX byte FIFO; push and pop may coincide, including when full.
module per_uart_fifo
    import per_uart_tx_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = BYTE_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign full      = (r_count == FULL_CNT);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    // A full FIFO still accepts a byte when the head leaves in the same cycle
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    // Storage array: data only, no reset needed
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/per_uart_tx.sv
// xSimBus slot-3 UART transmitter: register decode, baud counter and 8N1 framing FSM.
module per_uart_tx
    import per_uart_tx_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int BAUD_DIV_RESET = 868
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SEL_W-1:0]      select_as_in,
    input  logic [DEV_ADDR_W-1:0] addr_in,
    input  logic [WORD_W-1:0]     data_in,
    output logic [WORD_W-1:0]     data_out,
    input  logic                  rw_in,
    output logic                  tx_out,
    output logic                  irq_out
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic              w_hit;
    logic [1:0]        w_off;
    logic              w_wr;
    logic              w_rd;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [CW-1:0]     w_count;
    logic [BYTE_W-1:0] w_dout;
    logic [WORD_W-1:0] w_status;
    logic              w_unused;

    logic [15:0]       r_baud_div;
    logic              r_irq_en;
    logic              r_ovf;
    uart_state_e       r_state;
    logic [BYTE_W-1:0] r_shift;
    logic [15:0]       r_div;
    logic [15:0]       r_baud_cnt;
    logic [2:0]        r_bit_cnt;
    logic              r_tx;

    // Only the first 16 bytes of the slot are populated; higher addresses are holes
    assign w_hit    = (select_as_in == SEL_SLAVE) && (addr_in[DEV_ADDR_W-1:4] == '0);
    assign w_off    = addr_in[3:2];
    assign w_wr     = w_hit && (rw_in == RW_W);
    assign w_rd     = w_hit && (rw_in == RW_R);
    assign w_push   = w_wr && (w_off == OFF_TXDATA);
    assign w_unused = ^{data_in[WORD_W-1:16], addr_in[1:0]};

    // The FSM takes the head when idle, or at the end of a stop bit to chain frames
    assign w_pop = !w_empty &&
                   ((r_state == ST_IDLE) ||
                    ((r_state == ST_STOP) && (r_baud_cnt == 16'd0)));

    per_uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (BYTE_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (data_in[BYTE_W-1:0]),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    // Software-visible control registers and the sticky overflow flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_baud_div <= 16'(BAUD_DIV_RESET);
            r_irq_en   <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_push && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end
            if (w_wr) begin
                case (w_off)
                    OFF_STATUS: if (data_in[3]) r_ovf <= 1'b0;
                    OFF_BAUD:   r_baud_div <= baud_sanitize(data_in[15:0]);
                    OFF_CTRL:   r_irq_en   <= data_in[0];
                    default:    ;
                endcase
            end
        end
    end

    // Frame sequencer: the divider is latched per frame so BAUD writes never split a frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_tx       <= 1'b1;
            r_div      <= 16'd1;
            r_baud_cnt <= 16'd0;
            r_bit_cnt  <= 3'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_state    <= ST_START;
                        r_tx       <= 1'b0;
                        r_div      <= r_baud_div;
                        r_baud_cnt <= r_baud_div - 16'd1;
                    end
                end
                ST_START: begin
                    if (r_baud_cnt == 16'd0) begin
                        r_state    <= ST_DATA;
                        r_tx       <= r_shift[0];
                        r_baud_cnt <= r_div - 16'd1;
                        r_bit_cnt  <= 3'd0;
                    end else begin
                        r_baud_cnt <= r_baud_cnt - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (r_baud_cnt == 16'd0) begin
                        r_baud_cnt <= r_div - 16'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= ST_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt - 16'd1;
                    end
                end
                ST_STOP: begin
                    if (r_baud_cnt == 16'd0) begin
                        if (w_pop) begin
                            r_state    <= ST_START;
                            r_tx       <= 1'b0;
                            r_div      <= r_baud_div;
                            r_baud_cnt <= r_baud_div - 16'd1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt - 16'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    // Shift register: loaded on pop, advanced at each data-bit boundary
    always_ff @(posedge clk) begin
        if (w_pop) begin
            r_shift <= w_dout;
        end else if ((r_state == ST_DATA) && (r_baud_cnt == 16'd0)) begin
            r_shift <= r_shift >> 1;
        end
    end

    assign tx_out  = r_tx;
    assign irq_out = w_empty && r_irq_en && (r_state == ST_IDLE);

    // Combinational read mux; forced to zero while reset is held
    always_comb begin
        w_status        = ZERO_WORD;
        w_status[0]     = w_full;
        w_status[1]     = w_empty;
        w_status[2]     = (r_state != ST_IDLE);
        w_status[3]     = r_ovf;
        w_status[13:8]  = 6'(w_count);
        data_out        = ZERO_WORD;
        if (rst && w_rd) begin
            case (w_off)
                OFF_STATUS: data_out = w_status;
                OFF_BAUD:   data_out = {16'd0, r_baud_div};
                OFF_CTRL:   data_out = {31'd0, r_irq_en};
                default:    data_out = ZERO_WORD;
            endcase
        end
    end

endmodule
